// File: rtl/conv1d_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv1d_engine                                                   |
// | Purpose  : 1-D "same" convolution accelerator behind a CFU command port.   |
// |            Holds input vector, kernel, bias and requant settings and       |
// |            computes LANES saturated outputs per COMPUTE cycle.             |
// | Ports    : clk, reset          clock / synchronous active-high reset       |
// |            cmd_valid/ready     command handshake (ready only in IDLE)      |
// |            cmd_op/arg0/arg1    opcode and two 32-bit arguments             |
// |            rsp_valid/ready     response handshake, held until accepted     |
// |            rsp_data            response payload (FFFF_FFFF on error)       |
// |            busy                high while computing                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module conv1d_engine #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int KERNEL_LEN = 8,
  parameter int MAX_LEN    = 1024,
  parameter int LANES      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_arg0,
  input  logic [31:0] cmd_arg1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);
  localparam int AW   = $clog2(MAX_LEN);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int GW   = $clog2(MAX_LEN / LANES + 1);
  localparam int KIW  = $clog2(KERNEL_LEN);
  localparam int HALF = KERNEL_LEN / 2;
  localparam int WIN  = LANES + KERNEL_LEN - 1;
  // Tap = sample + 9-bit offset; one extra bit so the sum never wraps.
  localparam int TW   = ((DATA_W > 9) ? DATA_W : 9) + 1;

  localparam logic [3:0] c_OP_CLEAR  = 4'd0;
  localparam logic [3:0] c_OP_WR_IN  = 4'd1;
  localparam logic [3:0] c_OP_WR_KER = 4'd2;
  localparam logic [3:0] c_OP_RD_OUT = 4'd3;
  localparam logic [3:0] c_OP_SETLEN = 4'd4;
  localparam logic [3:0] c_OP_START  = 4'd5;
  localparam logic [3:0] c_OP_BIAS   = 4'd6;
  localparam logic [3:0] c_OP_QUANT  = 4'd7;
  localparam logic [3:0] c_OP_STATUS = 4'd8;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_COMPUTE = 2'd1;
  localparam logic [1:0] c_ST_RESP    = 2'd2;

  localparam logic [31:0]             c_ERR     = 32'hFFFF_FFFF;
  localparam logic signed [ACC_W-1:0] c_ONE     = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ~c_SAT_MAX;

  // Storage (not reset)
  logic signed [DATA_W-1:0] r_x [MAX_LEN];
  logic signed [DATA_W-1:0] r_y [MAX_LEN];
  logic signed [DATA_W-1:0] r_w [KERNEL_LEN];

  // Control / configuration
  logic [LW-1:0]           r_len;
  logic signed [ACC_W-1:0] r_bias;
  logic signed [8:0]       r_in_off;
  logic [4:0]              r_shift;
  logic [1:0]              r_state;
  logic [GW-1:0]           r_group;
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_data;

  logic                    w_accept;
  logic                    w_err;
  logic                    w_go;
  logic [31:0]             w_rsp;
  logic [AW-1:0]           w_ebase;
  logic                    w_x_ok;
  logic                    w_k_ok;
  logic [31:0]             w_base;
  logic                    w_last;
  logic [31:0]             w_j   [WIN];
  logic signed [TW-1:0]    w_win [WIN];
  logic signed [ACC_W-1:0] w_acc [LANES];
  logic signed [ACC_W-1:0] w_rnd [LANES];
  logic signed [DATA_W-1:0] w_y  [LANES];

  assign cmd_ready = (r_state == c_ST_IDLE);
  assign busy      = (r_state == c_ST_COMPUTE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  assign w_accept = cmd_valid & cmd_ready;
  assign w_ebase  = AW'(cmd_arg0 << 2);
  // Word-index bounds checked on arg0 itself so 4*arg0 cannot overflow.
  assign w_x_ok   = cmd_arg0 < 32'(MAX_LEN / 4);
  assign w_k_ok   = cmd_arg0 < 32'((KERNEL_LEN + 3) / 4);
  assign w_base   = 32'(r_group) * 32'(LANES);
  assign w_last   = (w_base + 32'(LANES)) >= 32'(r_len);

  // Command decode: error flag and response payload for the accepted command.
  always_comb begin
    w_err = 1'b0;
    w_go  = 1'b0;
    w_rsp = '0;
    case (cmd_op)
      c_OP_CLEAR, c_OP_BIAS, c_OP_QUANT: ;
      c_OP_WR_IN:  w_err = !w_x_ok;
      c_OP_WR_KER: w_err = !w_k_ok;
      c_OP_RD_OUT: begin
        w_err = !w_x_ok;
        for (int e = 0; e < 4; e++)
          w_rsp[(3 - e) * DATA_W +: DATA_W] = r_y[w_ebase + AW'(e)];
      end
      c_OP_SETLEN: w_err = cmd_arg0 > 32'(MAX_LEN);
      c_OP_START:  w_go  = (r_len != '0);
      c_OP_STATUS: w_rsp = {16'(r_len), 11'b0, r_shift};
      default:     w_err = 1'b1;
    endcase
    if (w_err) w_rsp = c_ERR;
  end

  // Shared tap window for the current group. Indices below zero wrap to huge
  // unsigned values, so one compare against len masks both padding sides.
  always_comb begin
    for (int t = 0; t < WIN; t++) begin
      w_j[t]   = w_base + 32'(t) - 32'(HALF);
      w_win[t] = (w_j[t] < 32'(r_len)) ?
                 (TW'(r_x[w_j[t][AW-1:0]]) + TW'(r_in_off)) : '0;
    end
  end

  // Per-lane MAC, rounded arithmetic shift and saturation.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_acc[l] = r_bias;
      for (int k = 0; k < KERNEL_LEN; k++)
        w_acc[l] = w_acc[l] + ACC_W'(w_win[l + k]) * ACC_W'(r_w[k]);
      if (r_shift != 5'd0)
        w_rnd[l] = (w_acc[l] + (c_ONE <<< (r_shift - 5'd1))) >>> r_shift;
      else
        w_rnd[l] = w_acc[l];
      if (w_rnd[l] > c_SAT_MAX)
        w_y[l] = DATA_W'(c_SAT_MAX);
      else if (w_rnd[l] < c_SAT_MIN)
        w_y[l] = DATA_W'(c_SAT_MIN);
      else
        w_y[l] = w_rnd[l][DATA_W-1:0];
    end
  end

  // Buffer writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_accept && !w_err) begin
        case (cmd_op)
          c_OP_CLEAR:
            for (int k = 0; k < KERNEL_LEN; k++) r_w[k] <= '0;
          c_OP_WR_IN:
            for (int e = 0; e < 4; e++)
              r_x[w_ebase + AW'(e)] <= cmd_arg1[(3 - e) * DATA_W +: DATA_W];
          c_OP_WR_KER:
            // Last word may be partial when KERNEL_LEN is not a multiple of 4.
            for (int e = 0; e < 4; e++)
              if (((cmd_arg0 << 2) + 32'(e)) < 32'(KERNEL_LEN))
                r_w[KIW'((cmd_arg0 << 2) + 32'(e))] <= cmd_arg1[(3 - e) * DATA_W +: DATA_W];
          default: ;
        endcase
      end
      if (r_state == c_ST_COMPUTE)
        for (int l = 0; l < LANES; l++)
          if ((w_base + 32'(l)) < 32'(r_len))
            r_y[AW'(w_base + 32'(l))] <= w_y[l];
    end
  end

  // Control FSM and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_group     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_len       <= '0;
      r_bias      <= '0;
      r_in_off    <= '0;
      r_shift     <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_group    <= '0;
            r_rsp_data <= w_rsp;
            if (w_go) begin
              r_state <= c_ST_COMPUTE;
            end else begin
              r_state     <= c_ST_RESP;
              r_rsp_valid <= 1'b1;
            end
            if (!w_err) begin
              case (cmd_op)
                c_OP_CLEAR: begin
                  r_len    <= '0;
                  r_bias   <= '0;
                  r_in_off <= '0;
                  r_shift  <= '0;
                end
                c_OP_SETLEN: r_len  <= LW'(cmd_arg0);
                c_OP_BIAS:   r_bias <= ACC_W'(cmd_arg0);
                c_OP_QUANT: begin
                  r_in_off <= $signed(cmd_arg0[8:0]);
                  r_shift  <= cmd_arg1[4:0];
                end
                default: ;
              endcase
            end
          end
        end
        c_ST_COMPUTE: begin
          if (w_last) begin
            r_state     <= c_ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
          end else begin
            r_group <= r_group + 1'b1;
          end
        end
        c_ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
